// File: rtl/stream_demux2.sv
// 1-to-2 packet demultiplexer: steers a valid/ready stream to channel A or B, locking
// the destination per packet, with a one-entry register stage per output. Optional
// per-channel delivered-packet counters under DEMUX_STATS_EN.
module stream_demux2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_sel,
    input  logic          in_last,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [DW-1:0] a_data,
    output logic          a_last,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [DW-1:0] b_data,
    output logic          b_last,
    output logic          busy
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]   pkt_cnt_a,
    output logic [15:0]   pkt_cnt_b
`endif
);

    typedef enum logic [1:0] {IDLE, PKT_A, PKT_B} state_e;

    state_e               state_q, state_d;
    logic                 dest;
    logic                 acc;
    logic [1:0]           acc_ch;
    logic [1:0]           rdy;
    logic [1:0]           vld_q;
    logic [1:0]           last_q;
    logic [1:0][DW-1:0]   data_q;

    assign rdy = {b_ready, a_ready};

    // Destination is taken from in_sel only while no packet is open.
    always_comb begin
        dest = in_sel;
        case (state_q)
            PKT_A:   dest = 1'b0;
            PKT_B:   dest = 1'b1;
            default: dest = in_sel;
        endcase
    end

    assign in_ready = ~vld_q[dest] | rdy[dest];
    assign acc      = in_valid & in_ready;
    assign acc_ch   = {acc & dest, acc & ~dest};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc && !in_last) state_d = in_sel ? PKT_B : PKT_A;
            PKT_A,
            PKT_B:   if (acc && in_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Output stages: a load wins over a drain, so simultaneous drain+accept reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            last_q <= '0;
            data_q <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (acc_ch[c]) begin
                    vld_q[c]  <= 1'b1;
                    data_q[c] <= in_data;
                    last_q[c] <= in_last;
                end else if (vld_q[c] && rdy[c]) begin
                    vld_q[c]  <= 1'b0;
                end
            end
        end
    end

    assign a_valid = vld_q[0];
    assign a_data  = data_q[0];
    assign a_last  = last_q[0];
    assign b_valid = vld_q[1];
    assign b_data  = data_q[1];
    assign b_last  = last_q[1];
    assign busy    = (state_q != IDLE);

`ifdef DEMUX_STATS_EN
    logic [1:0][15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int c = 0; c < 2; c++)
                if (vld_q[c] && rdy[c] && last_q[c] && cnt_q[c] != 16'hFFFF)
                    cnt_q[c] <= cnt_q[c] + 16'd1;
        end
    end

    assign pkt_cnt_a = cnt_q[0];
    assign pkt_cnt_b = cnt_q[1];
`endif

endmodule
